// File: rtl/registradores_pkg.sv
// Core-wide constants shared by the integer datapath.
// Register file geometry and the hardwired-zero register index.
package registradores_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/registradores.sv
// Integer register file: 32 x XLEN, two async read ports, one sync write.
// x0 has no storage and always reads zero.
module registradores
    import registradores_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  wr,
    output logic [DATA_WIDTH-1:0] read1,
    output logic [DATA_WIDTH-1:0] read2
);

    localparam int                    LAST = 2 ** ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs [1:LAST];

    logic rd_zero;
    logic rs1_zero;
    logic rs2_zero;

    assign rd_zero  = (rd == ZERO);
    assign rs1_zero = (rs1 == ZERO);
    assign rs2_zero = (rs2 == ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= LAST; i++) begin
                regs[i] <= '0;
            end
        end else if (wr && !rd_zero) begin
            regs[rd] <= write_data;
        end
    end

    // No bypass: a same-cycle write is visible only after the edge.
    assign read1 = rs1_zero ? '0 : regs[rs1];
    assign read2 = rs2_zero ? '0 : regs[rs2];

endmodule

// File: tb/tb_registradores.sv
// Self-checking bench for registradores against an array reference model.
module tb_registradores;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        wr;
    logic [31:0] read1;
    logic [31:0] read2;

    logic [31:0] model [32];
    int checks;
    int errors;

    registradores dut (
        .clk        (clk),
        .rst        (rst),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .write_data (write_data),
        .wr         (wr),
        .read1      (read1),
        .read2      (read2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] expect_reg(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : model[idx];
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag,
                              input logic [4:0] a,
                              input logic [4:0] b);
        rs1 = a;
        rs2 = b;
        #1;
        check({tag, "/read1"}, read1, expect_reg(a));
        check({tag, "/read2"}, read2, expect_reg(b));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (wr && rd != 5'd0) begin
            model[rd] = write_data;
        end
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'hxxxx_xxxx;
        rst = 1'b1;
        wr = 1'b0;
        rd = 5'd0;
        write_data = 32'd0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        tick();
        tick();
        rst = 1'b0;

        read_check("reset_1_2", 5'd1, 5'd2);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            check("reset_all_r1", read1, 32'd0);
            check("reset_all_r2", read2, 32'd0);
        end

        rd = 5'd4; write_data = 32'd1234; wr = 1'b1;
        tick();
        wr = 1'b0;
        read_check("write_x4", 5'd4, 5'd1);
        check("x4_const", read1, 32'd1234);

        rd = 5'd5; write_data = 32'd5678; wr = 1'b1;
        rs1 = 5'd5; rs2 = 5'd0;
        #1;
        check("x5_pre_edge", read1, 32'd0);
        tick();
        wr = 1'b0;
        #1;
        check("x5_post_r1", read1, 32'd5678);
        check("x5_post_r2", read2, 32'd0);

        rd = 5'd0; write_data = 32'hDEAD_BEEF; wr = 1'b1;
        tick();
        wr = 1'b0;
        read_check("x0_write", 5'd0, 5'd0);
        check("x0_const", read1, 32'd0);

        rd = 5'd7; write_data = 32'd99; wr = 1'b0;
        tick(); tick(); tick();
        read_check("x7_no_wr", 5'd7, 5'd7);
        check("x7_const", read1, 32'd0);

        rd = 5'd31; write_data = 32'hFFFF_FFFF; wr = 1'b1;
        tick();
        read_check("x31_ones", 5'd31, 5'd4);
        check("x31_ones_const", read1, 32'hFFFF_FFFF);
        rst = 1'b1; write_data = 32'd1;
        tick();
        rst = 1'b0;
        wr = 1'b0;
        read_check("x31_rst", 5'd31, 5'd4);
        check("x31_rst_const", read1, 32'd0);
        wr = 1'b1;
        tick();
        wr = 1'b0;
        read_check("x31_after", 5'd31, 5'd31);
        check("x31_after_const", read1, 32'd1);

        rd = 5'd9; wr = 1'b1;
        write_data = 32'hAAAA_0001;
        tick();
        write_data = 32'hAAAA_0002;
        tick();
        wr = 1'b0;
        read_check("back_to_back", 5'd9, 5'd9);
        check("back_to_back_const", read2, 32'hAAAA_0002);

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            wr = $urandom_range(0, 3) != 0;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            write_data = $urandom;
            read_check("rand_pre", 5'($urandom), rd);
            tick();
            read_check("rand_post", rd, 5'($urandom));
        end

        rst = 1'b0;
        wr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_check("final_sweep", 5'(i), 5'(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
